// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: branch kinds, fetch FSM states and instruction size.
package cpu_pkg;
  typedef enum logic [1:0] {
    BR_COND   = 2'd0,
    BR_UNCOND = 2'd1,
    BR_REG    = 2'd2
  } br_kind_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO for fetched {pc, instr} words; 0-cycle head read, flush wins over push/pop.
// Caller must not push when full unless popping in the same cycle.
module fetch_queue #(
  parameter int W     = 96,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, resolves redirect targets and queues words for decode.
// Redirects take priority over everything and flush the queue; first redirected word reaches decode 2 cycles later.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                Q_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               halt_req,
  input  logic               br_valid,
  input  logic [1:0]         br_kind,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [25:0]        br_imm,
  input  logic [ADDR_W-1:0]  br_reg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_link,
  output logic               align_err
);
  localparam int QW = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] target;
  logic              redirect;
  logic              pop;
  logic              q_full;
  logic              q_empty;
  logic [QW-1:0]     q_head;

  // Kind 2'b11 is not a branch, so it never redirects.
  assign redirect = br_valid && (state != S_IDLE) && (br_kind != 2'b11);

  always_comb begin
    target = fetch_pc;
    case (br_kind)
      BR_COND:   target = br_pc + {{(ADDR_W-21){br_imm[18]}}, br_imm[18:0], 2'b00};
      BR_UNCOND: target = br_pc + {{(ADDR_W-28){br_imm[25]}}, br_imm[25:0], 2'b00};
      BR_REG:    target = {br_reg[ADDR_W-1:2], 2'b00};
      default:   target = fetch_pc;
    endcase
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_RUN;
      S_RUN: begin
        if (halt_req) state_nxt = S_HALT;
        imem_req = !redirect && (!q_full || pop);
      end
      S_HALT: if (!halt_req) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      align_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      align_err <= redirect && (br_kind == BR_REG) && (br_reg[1:0] != 2'b00);
      if (redirect)      fetch_pc <= target;
      else if (imem_req) fetch_pc <= fetch_pc + STEP;
    end
  end

  assign imem_addr = fetch_pc;
  assign out_valid = !q_empty && !redirect;
  assign pop       = out_valid && out_ready;

  fetch_queue #(
    .W     (QW),
    .DEPTH (Q_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (imem_req),
    .push_data ({fetch_pc, imem_instr}),
    .pop       (pop),
    .flush     (redirect),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  assign out_pc    = q_head[QW-1:INSTR_W];
  assign out_instr = q_head[INSTR_W-1:0];
  assign out_link  = out_pc + STEP;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model under directed and random stimulus,
// plus a second instance reset near the top of the address space to exercise PC wrap.
module tb_fetch_unit;
  localparam int QD = 4;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, halt_req, br_valid, out_ready;
  logic [1:0]  br_kind;
  logic [63:0] br_pc, br_reg;
  logic [25:0] br_imm;
  logic [63:0] imem_addr, out_pc, out_link;
  logic [31:0] imem_instr, out_instr;
  logic        imem_req, out_valid, align_err;

  logic        w_reset;
  logic [63:0] w_imem_addr, w_out_pc, w_out_link;
  logic [31:0] w_imem_instr, w_out_instr;
  logic        w_imem_req, w_out_valid, w_align_err;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[63:48]} ^ 32'hC0DE_0000;
  endfunction

  assign imem_instr   = mem_word(imem_addr);
  assign w_imem_instr = mem_word(w_imem_addr);

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_instr(imem_instr), .halt_req(halt_req), .br_valid(br_valid),
    .br_kind(br_kind), .br_pc(br_pc), .br_imm(br_imm), .br_reg(br_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_link(out_link), .align_err(align_err)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .reset(w_reset), .imem_addr(w_imem_addr), .imem_req(w_imem_req),
    .imem_instr(w_imem_instr), .halt_req(1'b0), .br_valid(1'b0),
    .br_kind(2'b00), .br_pc(64'd0), .br_imm(26'd0), .br_reg(64'd0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_instr(w_out_instr),
    .out_pc(w_out_pc), .out_link(w_out_link), .align_err(w_align_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: queue of fetched PCs, next fetch PC, run/halt flags.
  logic [63:0] mq[$];
  logic [63:0] m_pc;
  bit          m_live, m_halted, m_align;

  function automatic logic [63:0] branch_target(input logic [1:0] k, input logic [63:0] pc,
                                                input logic [25:0] imm, input logic [63:0] r);
    longint off;
    case (k)
      2'd0: begin
        off = longint'(imm[18:0]);
        if (off >= 2**18) off -= 2**19;
        return pc + 64'(off * 4);
      end
      2'd1: begin
        off = longint'(imm);
        if (off >= 2**25) off -= 2**26;
        return pc + 64'(off * 4);
      end
      default: return r - 64'(r[1:0]);
    endcase
  endfunction

  task automatic model_cycle();
    bit redir, ev, pop, req;
    if (reset) begin
      mq.delete();
      m_pc = 64'd0; m_live = 0; m_halted = 0; m_align = 0;
      return;
    end
    redir = br_valid && m_live && (br_kind != 2'b11);
    ev    = (mq.size() > 0) && !redir;
    pop   = ev && out_ready;
    req   = m_live && !m_halted && !redir && ((mq.size() < QD) || pop);
    check("out_valid", out_valid, ev);
    check("imem_req", imem_req, req);
    check("align_err", align_err, m_align);
    if (ev) begin
      check("out_pc", out_pc, mq[0]);
      check("out_instr", out_instr, mem_word(mq[0]));
      check("out_link", out_link, mq[0] + 64'd4);
    end
    if (req) check("imem_addr", imem_addr, m_pc);
    if (redir) begin
      mq.delete();
      m_pc    = branch_target(br_kind, br_pc, br_imm, br_reg);
      m_align = (br_kind == 2'd2) && (br_reg[1:0] != 2'b00);
    end else begin
      m_align = 0;
      if (pop) void'(mq.pop_front());
      if (req) begin
        mq.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
    end
    m_halted = m_live ? halt_req : 1'b0;
    m_live   = 1;
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [1:0] k, input logic [63:0] pc,
                          input logic [25:0] imm, input logic [63:0] r);
    br_valid = 1'b1; br_kind = k; br_pc = pc; br_imm = imm; br_reg = r;
    tick();
    br_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; halt_req = 1'b0; br_valid = 1'b0; out_ready = 1'b0;
    br_kind = 2'b00; br_pc = '0; br_imm = '0; br_reg = '0;
    repeat (2) tick();
    reset = 1'b0; out_ready = 1'b1;
    repeat (12) tick();

    out_ready = 1'b0;
    repeat (10) tick();
    #1 check("full_no_req", imem_req, 1'b0);
    out_ready = 1'b1;
    repeat (8) tick();

    redirect(2'd0, 64'h40, 26'h7FFFE, 64'd0);
    tick();
    #1 check("cond_tgt", out_pc, 64'h38);
    repeat (4) tick();

    redirect(2'd1, 64'h100, 26'h10, 64'd0);
    tick();
    #1 check("uncond_tgt", out_pc, 64'h140);
    repeat (3) tick();

    redirect(2'd2, 64'd0, 26'd0, 64'h203);
    #1 check("align_pulse", align_err, 1'b1);
    tick();
    #1 check("align_clear", align_err, 1'b0);
    check("reg_tgt", out_pc, 64'h200);
    repeat (3) tick();

    halt_req = 1'b1;
    repeat (8) tick();
    #1 check("halt_drained", out_valid, 1'b0);
    halt_req = 1'b0;
    repeat (6) tick();

    redirect(2'd3, 64'h500, 26'h3, 64'h7);
    repeat (3) tick();

    repeat (1500) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) halt_req = !halt_req;
      br_valid = ($urandom_range(0, 15) == 0);
      br_kind  = 2'($urandom_range(0, 3));
      br_pc    = {$urandom, $urandom};
      br_imm   = 26'($urandom);
      br_reg   = {$urandom, $urandom};
      reset    = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; br_valid = 1'b0; halt_req = 1'b0; out_ready = 1'b1;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Wrap instance: always ready, never halted, so after the dead cycle it streams one word per cycle.
  int          w_cyc;
  logic [63:0] w_exp;

  task automatic w_check();
    if (w_cyc < 2) begin
      check("w_idle", w_out_valid, 1'b0);
    end else begin
      check("w_valid", w_out_valid, 1'b1);
      check("w_pc", w_out_pc, w_exp);
      check("w_link", w_out_link, w_exp + 64'd4);
      check("w_instr", w_out_instr, mem_word(w_exp));
      w_exp = w_exp + 64'd4;
    end
    check("w_align", w_align_err, 1'b0);
    w_cyc++;
  endtask

  initial begin
    w_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 w_reset = 1'b0;
    w_cyc = 0; w_exp = WRAP_PC;
    repeat (8) begin
      @(negedge clk);
      w_check();
      @(posedge clk);
      #1;
    end
    w_reset = 1'b1;
    @(posedge clk);
    #1 w_reset = 1'b0;
    w_cyc = 0; w_exp = WRAP_PC;
    repeat (6) begin
      @(negedge clk);
      w_check();
      @(posedge clk);
      #1;
    end
  end
endmodule
